// File: rtl/hazard_unit_pkg.sv
// Shared constants for the hazard unit: bypass select encodings, select width
// computation and redirect kill-depth bounds.
package hazard_unit_pkg;

   // Bypass select encoding: 0 reads the register file, k selects in-flight stage k.
   localparam int BYPASS_REGFILE = 0;
   localparam int BYPASS_STAGE_X = 1;

   // Younger instructions squashed per redirect are limited to this range.
   localparam int KILL_DEPTH_MIN = 1;
   localparam int KILL_DEPTH_MAX = 4;
   localparam int KILL_CNT_W     = 2;

   // Width of one per-source bypass select field.
   function automatic int fwd_sel_w(input int fwd_depth);
      return $clog2(fwd_depth + 1);
   endfunction

   // Keep an out-of-range kill depth inside the supported window.
   function automatic int kill_depth_clamp(input int depth);
      if (depth < KILL_DEPTH_MIN) begin
         return KILL_DEPTH_MIN;
      end else if (depth > KILL_DEPTH_MAX) begin
         return KILL_DEPTH_MAX;
      end else begin
         return depth;
      end
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source priority match of one decode operand against the in-flight
// pipeline entries. The youngest matching stage wins; x0 never matches.
module hazard_match
   import hazard_unit_pkg::*;
#(
   parameter int FWD_DEPTH = 2,
   parameter int RAW       = 5
) (
   input  logic [RAW-1:0]                   rs,
   input  logic                             rs_used,
   input  logic [FWD_DEPTH-1:0]             valid,
   input  logic [FWD_DEPTH-1:0]             rd_we,
   input  logic [FWD_DEPTH*RAW-1:0]         rd,
   input  logic                             is_load_x,
   output logic [fwd_sel_w(FWD_DEPTH)-1:0]  sel,
   output logic                             load_hit
);

   localparam int SW = fwd_sel_w(FWD_DEPTH);

   logic [FWD_DEPTH-1:0] hit_s;
   logic [SW-1:0]        sel_s;

   // Find every producing stage, then let the youngest (lowest index) win.
   always_comb begin
      hit_s = '0;
      sel_s = SW'(BYPASS_REGFILE);
      for (int k = 0; k < FWD_DEPTH; k++) begin
         hit_s[k] = rs_used && valid[k] && rd_we[k] &&
                    (rd[k*RAW +: RAW] == rs) && (rs != '0);
      end
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (hit_s[k]) begin
            sel_s = SW'(BYPASS_STAGE_X + k);
         end else begin
            sel_s = sel_s;
         end
      end
   end

   // A hit on the X-stage entry holding a load is a load-use hazard.
   always_comb begin
      sel      = sel_s;
      load_hit = hit_s[0] && is_load_x;
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks in-flight destinations, selects X-stage bypass
// sources, stalls decode on load-use and memory stalls, and squashes younger
// instructions after a redirect.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int FWD_DEPTH  = 2,
   parameter int KILL_DEPTH = 1,
   parameter int RAW        = 5,
   parameter int CNT_W      = 32
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    id_valid,
   input  logic [NUM_SRC*RAW-1:0]                  id_rs,
   input  logic [NUM_SRC-1:0]                      id_rs_used,
   input  logic [RAW-1:0]                          id_rd,
   input  logic                                    id_rd_we,
   input  logic                                    id_is_load,
   input  logic                                    redirect,
   input  logic                                    mem_stall,
   output logic                                    stall_id,
   output logic                                    kill_id,
   output logic [NUM_SRC*fwd_sel_w(FWD_DEPTH)-1:0] x_fwd_sel,
   output logic                                    x_valid,
   output logic                                    x_rd_we,
   output logic [CNT_W-1:0]                        bubble_cnt
);

   localparam int SW = fwd_sel_w(FWD_DEPTH);
   localparam logic [KILL_CNT_W-1:0] KILL_LOAD =
      KILL_CNT_W'(kill_depth_clamp(KILL_DEPTH) - 1);

   // Entry k-1 in these vectors is pipeline stage k (index 0 is X).
   logic [FWD_DEPTH-1:0]     valid_r;
   logic [FWD_DEPTH-1:0]     we_r;
   logic [FWD_DEPTH*RAW-1:0] rd_r;
   // Only the X entry's load flag can create a load-use hazard.
   logic                     load_x_r;
   logic [NUM_SRC*SW-1:0]    sel_r;
   logic [KILL_CNT_W-1:0]    kill_cnt_r;
   logic                     pend_r;
   logic [CNT_W-1:0]         bubble_r;

   logic [NUM_SRC*SW-1:0]    sel_s;
   logic [NUM_SRC-1:0]       load_hit_s;
   logic                     advance_s;
   logic                     redirect_s;
   logic                     kill_s;
   logic                     load_use_s;
   logic                     stall_s;
   logic                     take_s;
   logic                     bubble_s;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      hazard_match #(
         .FWD_DEPTH (FWD_DEPTH),
         .RAW       (RAW)
      ) u_match (
         .rs        (id_rs[s*RAW +: RAW]),
         .rs_used   (id_rs_used[s]),
         .valid     (valid_r),
         .rd_we     (we_r),
         .rd        (rd_r),
         .is_load_x (load_x_r),
         .sel       (sel_s[s*SW +: SW]),
         .load_hit  (load_hit_s[s])
      );
   end

   // Cycle control: kill takes priority over load-use; an empty decode slot never stalls.
   always_comb begin
      advance_s  = !mem_stall;
      redirect_s = redirect || pend_r;
      kill_s     = advance_s && (redirect_s || (kill_cnt_r != '0));
      load_use_s = id_valid && (|load_hit_s);
      stall_s    = mem_stall || (load_use_s && !kill_s);
      take_s     = id_valid && !stall_s && !kill_s;
      bubble_s   = advance_s && id_valid && !take_s;
   end

   // Outputs are forced quiet while reset is asserted.
   always_comb begin
      stall_id   = !reset && stall_s;
      kill_id    = !reset && kill_s;
      x_valid    = !reset && valid_r[0];
      x_rd_we    = !reset && we_r[0];
      x_fwd_sel  = sel_r;
      bubble_cnt = bubble_r;
   end

   // Pipeline entries shift toward WB on every advancing cycle; X takes decode or a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r  <= '0;
         we_r     <= '0;
         rd_r     <= '0;
         load_x_r <= 1'b0;
      end else if (advance_s) begin
         for (int k = FWD_DEPTH - 1; k > 0; k--) begin
            valid_r[k]           <= valid_r[k-1];
            we_r[k]              <= we_r[k-1];
            rd_r[k*RAW +: RAW]   <= rd_r[(k-1)*RAW +: RAW];
         end
         valid_r[0]     <= take_s;
         we_r[0]        <= take_s && id_rd_we;
         rd_r[RAW-1:0]  <= take_s ? id_rd : '0;
         load_x_r       <= take_s && id_is_load;
      end
   end

   // Bypass selects follow the instruction into X and hold through memory stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_r <= '0;
      end else if (advance_s) begin
         sel_r <= sel_s;
      end
   end

   // Redirect kill countdown; a redirect seen under a memory stall waits as pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         kill_cnt_r <= '0;
         pend_r     <= 1'b0;
      end else if (advance_s) begin
         pend_r <= 1'b0;
         if (redirect_s) begin
            kill_cnt_r <= KILL_LOAD;
         end else if (kill_cnt_r != '0) begin
            kill_cnt_r <= kill_cnt_r - KILL_CNT_W'(1);
         end
      end else if (redirect) begin
         pend_r <= 1'b1;
      end
   end

   // Saturating count of bubbles inserted in place of a present decode instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_r <= '0;
      end else if (bubble_s && (bubble_r != '1)) begin
         bubble_r <= bubble_r + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a directed cycle table for the documented scenarios,
// then randomized traffic compared against a behavioural model.
module tb_hazard_unit;

   localparam int NUM_SRC    = 2;
   localparam int FWD_DEPTH  = 2;
   localparam int KILL_DEPTH = 2;
   localparam int RAW        = 5;
   localparam int CNT_W      = 4;
   localparam int SW         = 2;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;
   localparam int N_RAND     = 3000;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   id_valid;
   logic [NUM_SRC*RAW-1:0] id_rs;
   logic [NUM_SRC-1:0]     id_rs_used;
   logic [RAW-1:0]         id_rd;
   logic                   id_rd_we;
   logic                   id_is_load;
   logic                   redirect;
   logic                   mem_stall;
   logic                   stall_id;
   logic                   kill_id;
   logic [NUM_SRC*SW-1:0]  x_fwd_sel;
   logic                   x_valid;
   logic                   x_rd_we;
   logic [CNT_W-1:0]       bubble_cnt;

   always #5 clk = ~clk;

   hazard_unit #(
      .NUM_SRC    (NUM_SRC),
      .FWD_DEPTH  (FWD_DEPTH),
      .KILL_DEPTH (KILL_DEPTH),
      .RAW        (RAW),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rs_used (id_rs_used),
      .id_rd      (id_rd),
      .id_rd_we   (id_rd_we),
      .id_is_load (id_is_load),
      .redirect   (redirect),
      .mem_stall  (mem_stall),
      .stall_id   (stall_id),
      .kill_id    (kill_id),
      .x_fwd_sel  (x_fwd_sel),
      .x_valid    (x_valid),
      .x_rd_we    (x_rd_we),
      .bubble_cnt (bubble_cnt)
   );

   // One cycle: inputs, then outputs expected just before the next rising edge.
   typedef struct {
      int rst, idv, rs0, rs1, used, rd, we, ld, redir, ms;
      int e_stall, e_kill, e_xv, e_xwe, e_sel, e_bc;
   } vec_t;

   typedef struct {
      int v, rd, we, ld;
   } inst_t;

   vec_t  vq[$];
   int    n_vec = 0;
   int    n_bad = 0;

   // Reference model state: in-flight instructions, index 1 = X.
   inst_t pipe [1:FWD_DEPTH];
   int    m_sel [NUM_SRC];
   int    m_kill_left;
   int    m_pend;
   int    m_bubbles;

   function automatic void chk(input string name, input int idx, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, idx, act, exp);
      end
   endfunction

   task automatic drive(input vec_t v);
      reset      = (v.rst != 0);
      id_valid   = (v.idv != 0);
      id_rs      = {RAW'(v.rs1), RAW'(v.rs0)};
      id_rs_used = NUM_SRC'(v.used);
      id_rd      = RAW'(v.rd);
      id_rd_we   = (v.we != 0);
      id_is_load = (v.ld != 0);
      redirect   = (v.redir != 0);
      mem_stall  = (v.ms != 0);
   endtask

   task automatic check_outputs(input int idx, input int e_stall, input int e_kill,
                                input int e_xv, input int e_xwe, input int e_sel, input int e_bc);
      chk("stall_id",   idx, int'(stall_id),   e_stall);
      chk("kill_id",    idx, int'(kill_id),    e_kill);
      chk("x_valid",    idx, int'(x_valid),    e_xv);
      chk("x_rd_we",    idx, int'(x_rd_we),    e_xwe);
      chk("x_fwd_sel",  idx, int'(x_fwd_sel),  e_sel);
      chk("bubble_cnt", idx, int'(bubble_cnt), e_bc);
   endtask

   // Youngest in-flight stage writing the register, 0 if none or x0.
   function automatic int producer(input int rs, input int used);
      for (int k = 1; k <= FWD_DEPTH; k++) begin
         if (used != 0 && rs != 0 && pipe[k].v != 0 && pipe[k].we != 0 && pipe[k].rd == rs)
            return k;
      end
      return 0;
   endfunction

   initial begin
      vec_t v;
      int   prod [NUM_SRC];
      int   redir_now, killing, lu, stall;

      v = '{1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0};
      drive(v);

      // rst idv rs0 rs1 used rd we ld redir ms | stall kill xv xwe sel bc
      // add x5 ; add x6,x5,x1 -> src0 bypass from stage 1
      vq.push_back('{1,0,0,0,0, 0,0,0,0,0,  0,0,0,0, 0,0});
      vq.push_back('{0,1,1,2,3, 5,1,0,0,0,  0,0,0,0, 0,0});
      vq.push_back('{0,1,5,1,3, 6,1,0,0,0,  0,0,1,1, 0,0});
      vq.push_back('{0,0,0,0,0, 0,0,0,0,0,  0,0,1,1, 1,0});
      // lw x5 ; add x6,x5,x5 -> one stall, bubble, then both sources from stage 2
      vq.push_back('{0,1,2,0,1, 5,1,1,0,0,  0,0,0,0, 0,0});
      vq.push_back('{0,1,5,5,3, 6,1,0,0,0,  1,0,1,1, 0,0});
      vq.push_back('{0,1,5,5,3, 6,1,0,0,0,  0,0,0,0, 5,1});
      vq.push_back('{0,0,0,0,0, 0,0,0,0,0,  0,0,1,1,10,1});
      // writes to x0 (ALU and load) never bypass and never stall
      vq.push_back('{0,1,1,2,3, 0,1,0,0,0,  0,0,0,0, 0,1});
      vq.push_back('{0,1,0,0,3, 7,1,0,0,0,  0,0,1,1, 0,1});
      vq.push_back('{0,1,3,0,1, 0,1,1,0,0,  0,0,1,1, 0,1});
      vq.push_back('{0,1,0,0,3, 8,0,0,0,0,  0,0,1,1, 0,1});
      // redirect with kill depth 2 -> two killed decode slots, two bubbles in X
      vq.push_back('{0,1,0,0,0, 9,1,0,1,0,  0,1,1,0, 0,1});
      vq.push_back('{0,1,0,0,0,10,1,0,0,0,  0,1,0,0, 0,2});
      vq.push_back('{0,1,0,0,0,11,1,0,0,0,  0,0,0,0, 0,3});
      vq.push_back('{0,1,0,0,0,14,1,0,0,0,  0,0,1,1, 0,3});
      // mem_stall for 3 cycles, redirect in the first: frozen, kill after release
      vq.push_back('{0,1,0,0,0,12,1,0,1,1,  1,0,1,1, 0,3});
      vq.push_back('{0,1,0,0,0,12,1,0,0,1,  1,0,1,1, 0,3});
      vq.push_back('{0,1,0,0,0,12,1,0,0,1,  1,0,1,1, 0,3});
      vq.push_back('{0,1,0,0,0,12,1,0,0,0,  0,1,1,1, 0,3});
      vq.push_back('{0,1,0,0,0,13,1,0,0,0,  0,1,0,0, 0,4});
      vq.push_back('{0,0,0,0,0, 0,0,0,0,0,  0,0,0,0, 0,5});
      // reset during a load-use stall -> quiet outputs, next instruction unmodified
      vq.push_back('{0,1,0,0,0, 3,1,1,0,0,  0,0,0,0, 0,5});
      vq.push_back('{1,1,3,0,1, 4,1,0,0,0,  0,0,0,0, 0,5});
      vq.push_back('{0,1,3,0,1, 4,1,0,0,0,  0,0,0,0, 0,0});
      vq.push_back('{0,0,0,0,0, 0,0,0,0,0,  0,0,1,1, 0,0});

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i]);
         #2;
         check_outputs(i, vq[i].e_stall, vq[i].e_kill, vq[i].e_xv,
                       vq[i].e_xwe, vq[i].e_sel, vq[i].e_bc);
      end

      // Randomized phase, starting from a reset that the model mirrors.
      for (int i = 0; i < N_RAND; i++) begin
         v.rst   = (i == 0 || $urandom_range(0, 199) == 0) ? 1 : 0;
         v.idv   = ($urandom_range(0, 99) < 80) ? 1 : 0;
         v.rs0   = int'($urandom_range(0, 3));
         v.rs1   = int'($urandom_range(0, 3));
         v.used  = int'($urandom_range(0, 3));
         v.rd    = int'($urandom_range(0, 3));
         v.we    = ($urandom_range(0, 99) < 80) ? 1 : 0;
         v.ld    = ($urandom_range(0, 99) < 30) ? 1 : 0;
         v.redir = ($urandom_range(0, 99) < 8) ? 1 : 0;
         v.ms    = ($urandom_range(0, 99) < 15) ? 1 : 0;

         @(negedge clk);
         drive(v);
         #2;

         redir_now = (v.redir != 0 || m_pend != 0) ? 1 : 0;
         killing   = (v.ms == 0 && (redir_now != 0 || m_kill_left > 0)) ? 1 : 0;
         lu = 0;
         prod[0] = producer(v.rs0, v.used & 1);
         prod[1] = producer(v.rs1, (v.used >> 1) & 1);
         for (int s = 0; s < NUM_SRC; s++) begin
            if (v.idv != 0 && prod[s] == 1 && pipe[1].ld != 0) lu = 1;
         end
         stall = (v.ms != 0 || (lu != 0 && killing == 0)) ? 1 : 0;

         if (i > 0) begin
            check_outputs(vq.size() + i,
                          (v.rst != 0) ? 0 : stall,
                          (v.rst != 0) ? 0 : killing,
                          (v.rst != 0) ? 0 : pipe[1].v,
                          (v.rst != 0) ? 0 : pipe[1].we,
                          m_sel[1] * 4 + m_sel[0],
                          m_bubbles);
         end

         if (v.rst != 0) begin
            for (int k = 1; k <= FWD_DEPTH; k++) pipe[k] = '{0, 0, 0, 0};
            for (int s = 0; s < NUM_SRC; s++) m_sel[s] = 0;
            m_kill_left = 0;
            m_pend      = 0;
            m_bubbles   = 0;
         end else if (v.ms == 0) begin
            if (v.idv != 0 && (stall != 0 || killing != 0))
               m_bubbles = (m_bubbles < CNT_MAX) ? m_bubbles + 1 : CNT_MAX;
            for (int s = 0; s < NUM_SRC; s++) m_sel[s] = prod[s];
            for (int k = FWD_DEPTH; k > 1; k--) pipe[k] = pipe[k-1];
            if (v.idv != 0 && stall == 0 && killing == 0)
               pipe[1] = '{1, v.rd, v.we, v.ld};
            else
               pipe[1] = '{0, 0, 0, 0};
            if (redir_now != 0)
               m_kill_left = KILL_DEPTH - 1;
            else if (m_kill_left > 0)
               m_kill_left = m_kill_left - 1;
            m_pend = 0;
         end else if (v.redir != 0) begin
            m_pend = 1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
